// File: rtl/median_pkg.sv
// rtl/median_pkg.sv - shared types and helpers for the rank-order median filter
// Purpose: state encoding and rank arithmetic shared by median_rank_filter and median_cell.
// Contents: state_t {IDLE, LOAD}; mid_rank(n) = (n-1)/2; clamp_rank(rank, n) limits a rank to n-1.
package median_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Median slot of an odd-sized window
  function automatic int mid_rank(input int n);
    return (n - 1) / 2;
  endfunction

  // Ranks past the end of the window select the smallest sample
  function automatic int clamp_rank(input int rank, input int n);
    return (rank >= n) ? n - 1 : rank;
  endfunction

endpackage

// File: rtl/median_cell.sv
// rtl/median_cell.sv - one slot of the descending insertion-sorted sample array
// Purpose: computes the next value of a slot when a new sample is inserted.
// Ports:
//   own      in  W  this slot's current value
//   upper    in  W  value of the slot above (index k-1); ignored for slot 0
//   din      in  W  incoming sample
//   valid    in  1  this slot currently holds a window sample
//   upper_ge in  1  slot above is valid and >= din (tie to 1 for slot 0)
//   next_val out W  value this slot takes on insertion
//   ge       out 1  this slot is valid and >= din
module median_cell
  import median_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] own,
  input  logic [W-1:0] upper,
  input  logic [W-1:0] din,
  input  logic         valid,
  input  logic         upper_ge,
  output logic [W-1:0] next_val,
  output logic         ge
);

  // ge flags form a prefix over the sorted array; equal values count as ge,
  // so a new sample lands after existing equal samples.
  assign ge = valid && (own >= din);

  // Keep if at or above the insertion point, take din at the insertion
  // point, otherwise shift down from the slot above.
  assign next_val = ge ? own : (upper_ge ? din : upper);

endmodule

// File: rtl/median_rank_filter.sv
// rtl/median_rank_filter.sv - serial N-sample window, returns the sample at a chosen rank
// Purpose: insertion-sorts each window as samples arrive and outputs the selected rank
//          one edge after the window completes. Optional macro MEDIAN_RANK_EN enables the
//          per-window RANK input; without it the block is a fixed median filter.
// Ports:
//   CLK   in  1   clock, rising edge
//   nRST  in  1   asynchronous active-low reset
//   DI    in  W   sample input, valid while DSI=1
//   DSI   in  1   data strobe, high for N consecutive cycles per window
//   RANK  in  RW  output rank (0 = largest), sampled with the first sample of a window
//   DO    out W   selected-rank result, held until the next result
//   DSO   out 1   one-cycle pulse marking a new DO
//   BUSY  out 1   a window is partially loaded
module median_rank_filter
  import median_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 9,
  parameter int RW = $clog2(N)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [W-1:0]  DI,
  input  logic          DSI,
  input  logic [RW-1:0] RANK,
  output logic [W-1:0]  DO,
  output logic          DSO,
  output logic          BUSY
);

  localparam int MID = mid_rank(N);
  localparam int CW  = $clog2(N);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          done, done_next;
  logic          insert, first;
  logic [RW-1:0] rank_reg, rank_sel;

  logic [W-1:0]  s      [N];
  logic [W-1:0]  s_next [N];
  logic [W-1:0]  upper  [N];
  logic [N-1:0]  ge;
  logic [N-1:0]  upper_ge;
  logic [N-1:0]  valid;

  for (genvar k = 0; k < N; k++) begin : g_cell
    if (k == 0) begin : g_top
      assign upper[k]    = '0;
      assign upper_ge[k] = 1'b1;
    end else begin : g_rest
      assign upper[k]    = s[k-1];
      assign upper_ge[k] = ge[k-1];
    end

    // In IDLE the array is treated as empty so a new window starts at slot 0
    assign valid[k] = (state == LOAD) && (CW'(k) < cnt);

    median_cell #(.W(W)) u_cell (
      .own      (s[k]),
      .upper    (upper[k]),
      .din      (DI),
      .valid    (valid[k]),
      .upper_ge (upper_ge[k]),
      .next_val (s_next[k]),
      .ge       (ge[k])
    );
  end

`ifdef MEDIAN_RANK_EN
  assign rank_sel = RW'(clamp_rank(int'(RANK), N));
`else
  logic unused_rank;
  assign unused_rank = ^RANK;
  assign rank_sel    = RW'(MID);
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    insert     = 1'b0;
    first      = 1'b0;
    case (state)
      IDLE: begin
        if (DSI) begin
          insert     = 1'b1;
          first      = 1'b1;
          cnt_next   = CW'(1);
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (DSI) begin
          insert = 1'b1;
          if (cnt == CW'(N - 1)) begin
            cnt_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end else begin
          // Short window: discard it without touching the output
          cnt_next   = '0;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      rank_reg <= RW'(MID);
      DO       <= '0;
      DSO      <= 1'b0;
      for (int k = 0; k < N; k++) s[k] <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
      DSO   <= done;
      // Reads the pre-edge array, so the next window may start on this edge
      if (done) DO <= s[rank_reg];
      if (first) rank_reg <= rank_sel;
      if (insert) begin
        for (int k = 0; k < N; k++) s[k] <= s_next[k];
      end
    end
  end

  assign BUSY = (cnt != '0);

endmodule

// File: tb/tb_median_rank_filter.sv
// tb/tb_median_rank_filter.sv - self-checking bench for median_rank_filter
module tb_median_rank_filter;
  localparam int W   = 8;
  localparam int N   = 9;
  localparam int RW  = $clog2(N);
  localparam int MID = 4;

`ifdef MEDIAN_RANK_EN
  localparam int E_R0 = 200, E_R8 = 10, E_R12 = 10;
`else
  localparam int E_R0 = 60, E_R8 = 60, E_R12 = 60;
`endif

  logic          CLK  = 1'b0;
  logic          nRST = 1'b1;
  logic          DSI  = 1'b0;
  logic [W-1:0]  DI   = '0;
  logic [RW-1:0] RANK = '0;
  logic [W-1:0]  DO;
  logic          DSO, BUSY;

  always #5 CLK = ~CLK;

  median_rank_filter #(.W(W), .N(N), .RW(RW)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .DI   (DI),
    .DSI  (DSI),
    .RANK (RANK),
    .DO   (DO),
    .DSO  (DSO),
    .BUSY (BUSY)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: collect each window, sort it, pick the rank.
  logic [7:0] q[$];
  logic [7:0] srt[$];
  int         m_rank  = MID;
  logic       pending = 1'b0;
  logic [7:0] pend_val = '0;
  logic [7:0] exp_do  = '0;
  logic       exp_dso = 1'b0;
  logic       exp_busy = 1'b0;
  int         dso_cyc[$];
  int         dso_val[$];

  // Each negedge stands for the posedge just before it; inputs change at negedge+1.
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (!nRST) begin
        q.delete();
        pending = 1'b0;
        exp_do  = '0;
        exp_dso = 1'b0;
        m_rank  = MID;
      end else begin
        exp_dso = pending;
        if (pending) exp_do = pend_val;
        pending = 1'b0;
        if (DSI) begin
          if (q.size() == 0) begin
`ifdef MEDIAN_RANK_EN
            m_rank = (int'(RANK) >= N) ? N - 1 : int'(RANK);
`else
            m_rank = MID;
`endif
          end
          q.push_back(DI);
          if (q.size() == N) begin
            srt = q;
            srt.rsort();
            pend_val = srt[m_rank];
            pending  = 1'b1;
            q.delete();
          end
        end else begin
          q.delete();
        end
      end
      exp_busy = (q.size() != 0);
      if (DSO === 1'b1) begin
        dso_cyc.push_back(cyc);
        dso_val.push_back(int'(DO));
      end
      chk("dso", int'(DSO), int'(exp_dso));
      chk("do", int'(DO), int'(exp_do));
      chk("busy", int'(BUSY), int'(exp_busy));
    end
  end

  task automatic drive(input logic dsi, input logic [7:0] di, input logic [RW-1:0] rk);
    @(negedge CLK);
    #1;
    DSI  = dsi;
    DI   = di;
    RANK = rk;
  endtask

  task automatic run_window(input logic [7:0] v[N], input logic [RW-1:0] rk);
    for (int i = 0; i < N; i++) drive(1'b1, v[i], rk);
  endtask

  task automatic expect_result(input int exp, input string name);
    int lat;
    lat = 0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(negedge CLK);
      #1;
      DSI = 1'b0;
      #1;
      if (DSO === 1'b1) lat = i;
    end
    chk({name, "_latency"}, lat, 2);
    chk({name, "_value"}, int'(DO), exp);
    repeat (2) drive(1'b0, 8'd0, '0);
  endtask

  logic [7:0] win_a [N] = '{8'd10, 8'd200, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
  logic [7:0] win_7 [N] = '{default: 8'd7};
  logic [7:0] win_r [N];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1 nRST = 1'b0;
    #1;
    chk("reset_do", int'(DO), 0);
    chk("reset_dso", int'(DSO), 0);
    chk("reset_busy", int'(BUSY), 0);
    @(negedge CLK);
    #1 nRST = 1'b1;
    repeat (2) drive(1'b0, 8'd0, '0);

    run_window(win_a, 4);
    expect_result(60, "median");
    run_window(win_a, 0);
    expect_result(E_R0, "rank0");
    run_window(win_a, 8);
    expect_result(E_R8, "rank8");
    run_window(win_a, 12);
    expect_result(E_R12, "rank12");
    run_window(win_a, 4);
    expect_result(60, "median2");

    // Abort after 5 samples
    dso_cyc.delete();
    dso_val.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(i + 1), 4);
    repeat (4) drive(1'b0, 8'd0, 4);
    chk("abort_no_dso", dso_cyc.size(), 0);
    chk("abort_do_held", int'(DO), 60);
    chk("abort_busy", int'(BUSY), 0);
    run_window(win_7, 4);
    expect_result(7, "after_abort");

    // Back-to-back windows
    dso_cyc.delete();
    dso_val.delete();
    for (int i = 0; i < N; i++) drive(1'b1, 8'(i + 1), 4);
    for (int i = 0; i < N; i++) drive(1'b1, (i == 3) ? 8'd0 : 8'd255, 4);
    repeat (4) drive(1'b0, 8'd0, 4);
    chk("b2b_pulses", dso_cyc.size(), 2);
    if (dso_cyc.size() == 2) begin
      chk("b2b_spacing", dso_cyc[1] - dso_cyc[0], 9);
      chk("b2b_first", dso_val[0], 5);
      chk("b2b_second", dso_val[1], 255);
    end

    // Reset in the middle of a window
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(100 + i), 4);
    @(negedge CLK);
    #1;
    nRST = 1'b0;
    DSI  = 1'b0;
    #1;
    chk("midreset_do", int'(DO), 0);
    chk("midreset_dso", int'(DSO), 0);
    chk("midreset_busy", int'(BUSY), 0);
    @(negedge CLK);
    #1 nRST = 1'b1;
    run_window(win_a, 4);
    expect_result(60, "after_reset");

    // Random windows, some back-to-back, checked by the model
    for (int w = 0; w < 12; w++) begin
      logic [RW-1:0] rk;
      rk = RW'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) win_r[i] = 8'($urandom_range(0, 255));
      run_window(win_r, rk);
      if (w % 3 == 2) repeat (3) drive(1'b0, 8'd0, '0);
    end
    repeat (4) drive(1'b0, 8'd0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/median_rank_filter.md
Name: median_rank_filter

Overview:
- Parametrised successor to the 3x3 serial median block.
- Accepts a window of N samples of W bits serially, then returns the sample at a selectable rank, with a one-cycle valid pulse.
- Sorting is by insertion into a registered array as each sample arrives, so the result is ready one cycle after the last sample.
- Sits in the image-filter pipeline, driven by a window-fetch unit, and is used for median, min, max and rank-order denoising.

Parameters:
- W, 8: sample width in bits.
- N, 9: window size; odd, 3..31.
- RW, $clog2(N): width of the RANK port.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- DI  in  W  sample input, valid while DSI=1.
- DSI  in  1  data strobe in; high for N consecutive cycles per window.
- RANK  in  RW  output rank; 0 = largest, N-1 = smallest; sampled on the first sample of each window.
- DO  out  W  selected-rank result, held until the next result.
- DSO  out  1  one-cycle pulse marking a new DO.
- BUSY  out  1  high while a window is partially loaded (cnt != 0).

Behaviour:
- Reset: nRST low asynchronously forces the following, and any partial window is discarded.
  - state=IDLE, cnt=0, all array slots=0.
  - DO=0, DSO=0, BUSY=0, rank register = (N-1)/2.
- Storage: array S[0..N-1], sorted descending; slots k < cnt are valid.
- Insert rule, on each rising edge with DSI=1:
  - p = number of valid slots with S[k] >= DI.
  - S[p+1..cnt] <= S[p..cnt-1]; S[p] <= DI; cnt <= cnt+1.
  - Ties: a new sample goes after existing equal values.
- States: IDLE and LOAD.
  - IDLE, DSI=1: insert at slot 0 (the array is treated as empty), latch RANK, cnt=1, go to LOAD.
  - LOAD, DSI=1, cnt<N-1: insert.
  - LOAD, DSI=1, cnt=N-1: insert, cnt=0, raise done flag, go to IDLE.
  - LOAD, DSI=0: abort. cnt=0, go to IDLE, no DSO, DO unchanged.
- Output: at the edge after the done edge, DO <= S[rank_reg] and DSO=1 for exactly one cycle.
  - Latency is 2 edges from the capture of sample N to DO/DSO visible.
- Back-to-back windows: DSI may stay high for k*N cycles.
  - The first sample of window i+1 is captured on the same edge that loads DO from window i.
  - The output register reads the pre-edge array, so no bubble is needed.
  - Each window yields exactly one DSO.
- RANK >= N: clamp to N-1.
- DI is don't-care while DSI=0.
- Arithmetic: unsigned compare over W bits; no width growth.

Optional Feature:
- Macro: MEDIAN_RANK_EN.
- Defined: RANK is latched per window as described above.
- Undefined: RANK is ignored and rank_reg is fixed at (N-1)/2, i.e. a pure median. Port list is unchanged.

Decomposition:
- Package median_pkg holds:
  - state enum {IDLE, LOAD};
  - function clamp_rank;
  - localparam MID = (N-1)/2 as a function of N.
- One sub-module, median_cell: a single array slot.
  - Inputs: own value, upper neighbour's value, DI, valid bit, ge flag of upper neighbour.
  - Output: next value plus its own ge flag.
  - Instantiated N times with generate.

Test Plan:
- Median: N=9, W=8; DI = 10,200,30,40,50,60,70,80,90 with DSI high for 9 cycles -> one DSO pulse 2 edges after the last sample, DO=60.
- Rank (macro on): same window with RANK=0 -> DO=200. With RANK=8 -> DO=10. With RANK=12 -> DO=10 (clamped). Macro off with RANK=0 -> DO=60.
- Abort: DSI high for 5 samples then low, following an earlier DO=60 -> no DSO, DO stays 60, BUSY falls; the next full window of 9x 7 -> DO=7.
- Back-to-back: DSI high for 18 cycles, window A = 1..9, window B = 9x 255 with one 0 -> two DSO pulses exactly 9 cycles apart, DO=5 then DO=255.
- Reset mid-window: nRST pulsed low after 4 samples -> DO=0, DSO=0 immediately; the next full window produces a correct result.
- Image regression: 256x256 noisy 8-bit image fed as clamped 3x3 windows -> every DO matches the software sorted v[4]; write the filtered PGM and end with zero mismatches.
